fetch_queue: RTL and testbench

Circular FIFO between instruction fetch and `decoder`. It buffers each fetched instruction together with its PC and the fetch-stage branch prediction bit. It presents the oldest entry to decode through a valid/ready handshake, so fetch and decode stall independently. A redirect flush empties the queue.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: enqueue side from fetch, dequeue side to decode.
// The master modport is the fetch/decode environment; the slave modport is the queue.
interface fetch_queue_if #(
    parameter int PC_SIZE = 64
);
    logic               enq_valid;
    logic               enq_ready;
    logic [31:0]        enq_instruction;
    logic [PC_SIZE-1:0] enq_pc;
    logic               enq_branch_taken;
    logic               deq_valid;
    logic               deq_ready;
    logic [31:0]        deq_instruction;
    logic [PC_SIZE-1:0] deq_pc;
    logic               deq_branch_taken;

    modport master (
        output enq_valid, enq_instruction, enq_pc, enq_branch_taken, deq_ready,
        input  enq_ready, deq_valid, deq_instruction, deq_pc, deq_branch_taken
    );

    modport slave (
        input  enq_valid, enq_instruction, enq_pc, enq_branch_taken, deq_ready,
        output enq_ready, deq_valid, deq_instruction, deq_pc, deq_branch_taken
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO buffering {instruction, pc, branch_taken} between fetch and decode.
// Flush empties the queue without clearing storage; reset also zeroes storage.
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int PC_SIZE = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    fetch_queue_if.slave               bus,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int INSTR_W = 32;

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_SIZE-1:0] pc_q    [DEPTH];
    logic               bt_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic enq_fire;
    logic deq_fire;

    // Ready/valid come only from registered occupancy, so no input reaches an output.
    assign bus.enq_ready        = (count_q != CNT_W'(DEPTH));
    assign bus.deq_valid        = (count_q != '0);
    assign bus.deq_instruction  = instr_q[head_q];
    assign bus.deq_pc           = pc_q[head_q];
    assign bus.deq_branch_taken = bt_q[head_q];
    assign count                = count_q;

    assign enq_fire = bus.enq_valid && bus.enq_ready && !flush;
    assign deq_fire = bus.deq_valid && bus.deq_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (deq_fire) head_d = head_q + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                bt_q[i]    <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_fire) begin
                instr_q[tail_q] <= bus.enq_instruction;
                pc_q[tail_q]    <= bus.enq_pc;
                bt_q[tail_q]    <= bus.enq_branch_taken;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=8): reset, fill/drain, wrap, full+deq,
// flush, prediction alignment and mid-stream reset.
module tb_fetch_queue;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    fetch_queue_if #(.PC_SIZE(64)) fq_if ();

    fetch_queue #(.DEPTH(8), .PC_SIZE(64)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (fq_if),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic bt);
        fq_if.enq_valid        = v;
        fq_if.enq_instruction  = ins;
        fq_if.enq_pc           = pc;
        fq_if.enq_branch_taken = bt;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fq_if.deq_ready = 1'b0;
        drive_enq(1'b1, 32'hDEADBEEF, 64'h5555, 1'b1);

        // Reset held two cycles with enq_valid high
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(fq_if.deq_valid), 64'd0);
        check("rst_enq_ready", 64'(fq_if.enq_ready), 64'd1);
        check("rst_deq_instr", 64'(fq_if.deq_instruction), 64'd0);
        check("rst_deq_pc", fq_if.deq_pc, 64'd0);
        check("rst_deq_bt", 64'(fq_if.deq_branch_taken), 64'd0);
        reset = 1'b0;

        // Fill: eight accepts with decode stalled
        for (int i = 0; i < 8; i++) begin
            drive_enq(1'b1, 32'h100 + 32'(i), 64'h1000 + 64'(4 * i), i[0]);
            check("fill_enq_ready", 64'(fq_if.enq_ready), 64'd1);
            tick();
        end
        check("full_count", 64'(count), 64'd8);
        check("full_enq_ready", 64'(fq_if.enq_ready), 64'd0);
        drive_enq(1'b1, 32'h999, 64'h2000, 1'b0);
        tick();
        check("ninth_count", 64'(count), 64'd8);
        check("ninth_head_pc", fq_if.deq_pc, 64'h1000);
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);

        // Drain in order on consecutive cycles
        fq_if.deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 64'(fq_if.deq_valid), 64'd1);
            check("drain_pc", fq_if.deq_pc, 64'h1000 + 64'(4 * i));
            check("drain_instr", 64'(fq_if.deq_instruction), 64'h100 + 64'(i));
            check("drain_bt", 64'(fq_if.deq_branch_taken), 64'(i[0]));
            tick();
        end
        check("drained_valid", 64'(fq_if.deq_valid), 64'd0);
        check("drained_count", 64'(count), 64'd0);

        // Wrap-around: prime three entries, then 20 cycles of enq+deq
        fq_if.deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'hA000 + 32'(i), 64'h8000 + 64'(i), 1'b0);
            tick();
        end
        check("wrap_prime_count", 64'(count), 64'd3);
        fq_if.deq_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_enq(1'b1, 32'hA000 + 32'(c + 3), 64'h8000 + 64'(c + 3), 1'b0);
            check("wrap_instr", 64'(fq_if.deq_instruction), 64'hA000 + 64'(c));
            tick();
            check("wrap_count", 64'(count), 64'd3);
        end

        // Top up to full (head holds 0xA014, queue 0xA014..0xA016)
        fq_if.deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_enq(1'b1, 32'hA017 + 32'(i), 64'h0, 1'b0);
            tick();
        end
        check("topup_count", 64'(count), 64'd8);

        // Full with simultaneous dequeue: only the dequeue fires
        drive_enq(1'b1, 32'hB000, 64'hB000, 1'b1);
        fq_if.deq_ready = 1'b1;
        check("fulldeq_head", 64'(fq_if.deq_instruction), 64'hA014);
        tick();
        check("fulldeq_count7", 64'(count), 64'd7);
        check("fulldeq_enq_ready", 64'(fq_if.enq_ready), 64'd1);
        fq_if.deq_ready = 1'b0;
        tick();
        check("fulldeq_count8", 64'(count), 64'd8);
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);
        fq_if.deq_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("fulldeq_drain", 64'(fq_if.deq_instruction), 64'hA015 + 64'(i));
            tick();
        end
        check("fulldeq_last", 64'(fq_if.deq_instruction), 64'hB000);
        check("fulldeq_last_bt", 64'(fq_if.deq_branch_taken), 64'd1);
        tick();
        check("fulldeq_empty", 64'(fq_if.deq_valid), 64'd0);

        // Flush at count 5 with enq and deq both offered
        fq_if.deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_enq(1'b1, 32'hC000 + 32'(i), 64'h0, 1'b0);
            tick();
        end
        check("preflush_count", 64'(count), 64'd5);
        flush = 1'b1;
        fq_if.deq_ready = 1'b1;
        drive_enq(1'b1, 32'h00000013, 64'h3000, 1'b0);
        tick();
        flush = 1'b0;
        fq_if.deq_ready = 1'b0;
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_deq_valid", 64'(fq_if.deq_valid), 64'd0);
        check("flush_enq_ready", 64'(fq_if.enq_ready), 64'd1);
        drive_enq(1'b1, 32'hD000, 64'h4000, 1'b0);
        tick();
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);
        check("postflush_count", 64'(count), 64'd1);
        check("postflush_instr", 64'(fq_if.deq_instruction), 64'hD000);
        check("postflush_pc", fq_if.deq_pc, 64'h4000);
        fq_if.deq_ready = 1'b1;
        tick();
        check("postflush_alone", 64'(fq_if.deq_valid), 64'd0);

        // Prediction bit stays aligned with its instruction
        fq_if.deq_ready = 1'b0;
        drive_enq(1'b1, 32'h00208463, 64'h6000, 1'b1);
        tick();
        drive_enq(1'b1, 32'h002081B3, 64'h6004, 1'b0);
        tick();
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);
        check("pred_beq", 64'(fq_if.deq_instruction), 64'h00208463);
        check("pred_beq_bt", 64'(fq_if.deq_branch_taken), 64'd1);
        fq_if.deq_ready = 1'b1;
        tick();
        check("pred_add", 64'(fq_if.deq_instruction), 64'h002081B3);
        check("pred_add_bt", 64'(fq_if.deq_branch_taken), 64'd0);
        tick();
        check("pred_empty", 64'(fq_if.deq_valid), 64'd0);

        // Mid-stream reset discards entries and clears storage
        fq_if.deq_ready = 1'b0;
        drive_enq(1'b1, 32'hE000, 64'hE000, 1'b1);
        tick();
        drive_enq(1'b1, 32'hE001, 64'hE001, 1'b1);
        tick();
        reset = 1'b1;
        fq_if.deq_ready = 1'b1;
        tick();
        reset = 1'b0;
        fq_if.deq_ready = 1'b0;
        drive_enq(1'b0, 32'h0, 64'h0, 1'b0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_deq_valid", 64'(fq_if.deq_valid), 64'd0);
        check("midrst_instr", 64'(fq_if.deq_instruction), 64'd0);
        check("midrst_pc", fq_if.deq_pc, 64'd0);
        check("midrst_bt", 64'(fq_if.deq_branch_taken), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
